// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART link (uart_rx, uart_tx).
//   - frame constants (data bits, start/stop line levels)
//   - receiver state enum
//   - bit period / half period helpers derived from clock and baud rate
// Optional feature macro: UART_RX_PARITY_EN adds the RX_PARITY state (8E1 frames).
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;
`endif

    // Clock cycles per bit (integer division, truncating).
    function automatic int unsigned bit_period(input int unsigned freq,
                                               input int unsigned baud);
        return freq / baud;
    endfunction

    // Clock cycles to the middle of a bit.
    function automatic int unsigned half_period(input int unsigned freq,
                                                input int unsigned baud);
        return bit_period(freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk      in  1  destination clock
//   reset_n  in  1  asynchronous reset, active-low; all stages load RESET_VAL
//   d        in  1  asynchronous input
//   q        out 1  synchronized output, lags d by STAGES cycles
module uart_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 LSB first (8E1 with UART_RX_PARITY_EN defined).
// Samples mid-bit from a clock-count divider and holds each byte in a
// one-entry output register with a valid/ack handshake.
// Ports:
//   clk         in  1  system clock
//   reset_n     in  1  asynchronous reset, active-low
//   rx          in  1  asynchronous serial input, idle high
//   rdata       out 8  last received byte, valid while rvalid=1
//   rvalid      out 1  byte available, held until rdack
//   rdack       in  1  one-cycle consume strobe, ignored when rvalid=0
//   busy        out 1  frame reception in progress
//   frame_err   out 1  one-cycle pulse: stop bit sampled low
//   overrun     out 1  one-cycle pulse: byte completed while previous unread
//   parity_err  out 1  one-cycle pulse: even parity mismatch (0 without macro)
// Optional feature macro: UART_RX_PARITY_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_IDLE    | line idle, waiting for a falling edge on rx_s
// RX_START   | counting to mid start bit; high there means glitch
// RX_DATA    | sampling 8 data bits at mid-bit, LSB first
// RX_PARITY  | sampling the even parity bit (UART_RX_PARITY_EN only)
// RX_STOP    | sampling the stop bit; low means frame error
// RX_BREAK   | line held low after a frame error, waiting for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUDRATE = 115200,
    parameter int unsigned FREQ     = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rdack,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned T  = bit_period(FREQ, BAUDRATE);
    localparam int unsigned TH = half_period(FREQ, BAUDRATE);

    localparam logic [31:0] T_TC    = 32'(T - 1);
    localparam logic [31:0] TH_TC   = 32'(TH - 1);
    localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

    logic        rx_s;
    logic        rx_prev_q, rx_prev_d;

    rx_state_e   state_q, state_d;
    logic [31:0] cnt_clk_q, cnt_clk_d;
    logic [2:0]  cnt_bit_q, cnt_bit_d;
    logic [7:0]  shreg_q, shreg_d;

    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic        bit_tc;
    logic        stop_tc;
    logic        frame_good;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        parity_err_q, parity_err_d;
`endif

    uart_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Third flop: previous synchronized level, for falling-edge detection.
    assign rx_prev_d = rx_s;

    assign bit_tc  = (cnt_clk_q == T_TC);
    assign stop_tc = (state_q == RX_STOP) && bit_tc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_prev_q   <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_clk_q   <= '0;
            cnt_bit_q   <= '0;
            shreg_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            cnt_clk_q   <= cnt_clk_d;
            cnt_bit_q   <= cnt_bit_d;
            shreg_q     <= shreg_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clk_d = cnt_clk_q;
        cnt_bit_d = cnt_bit_q;
        shreg_d   = shreg_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d   = RX_START;
                    cnt_clk_d = '0;
                end
            end
            RX_START: begin
                if (cnt_clk_q == TH_TC) begin
                    if (rx_s != START_LVL) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        cnt_clk_d = '0;
                        cnt_bit_d = '0;
                    end
                end else begin
                    cnt_clk_d = cnt_clk_q + 32'd1;
                end
            end
            RX_DATA: begin
                if (bit_tc) begin
                    shreg_d[cnt_bit_q] = rx_s;
                    cnt_clk_d          = '0;
                    if (cnt_bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        cnt_bit_d = cnt_bit_q + 3'd1;
                    end
                end else begin
                    cnt_clk_d = cnt_clk_q + 32'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (bit_tc) begin
                    par_bad_d = (rx_s != ^shreg_q);
                    cnt_clk_d = '0;
                    state_d   = RX_STOP;
                end else begin
                    cnt_clk_d = cnt_clk_q + 32'd1;
                end
            end
`endif
            RX_STOP: begin
                if (bit_tc) begin
                    cnt_clk_d = '0;
                    state_d   = (rx_s == STOP_LVL) ? RX_IDLE : RX_BREAK;
                end else begin
                    cnt_clk_d = cnt_clk_q + 32'd1;
                end
            end
            RX_BREAK: begin
                // Leaving only on a high line keeps a held-low line to one frame_err.
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign frame_good = stop_tc && (rx_s == STOP_LVL) && !par_bad_q;
`else
    assign frame_good = stop_tc && (rx_s == STOP_LVL);
`endif

    always_comb begin
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_tc && (rx_s != STOP_LVL);
`ifdef UART_RX_PARITY_EN
        parity_err_d = (state_q == RX_PARITY) && bit_tc && (rx_s != ^shreg_q);
`endif
        if (frame_good) begin
            // An ack in the completion cycle frees the slot for the new byte.
            if (rvalid_q && !rdack) begin
                overrun_d = 1'b1;
            end else begin
                rdata_d  = shreg_q;
                rvalid_d = 1'b1;
            end
        end else if (rdack) begin
            rvalid_d = 1'b0;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = (state_q != RX_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
